// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one holding buffer per functional-unit result port,
// round-robin selection of one buffered result per cycle onto a registered broadcast.
module cdb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int TAG_W   = 5,
   parameter int PHY_W   = 6,
   parameter int DATA_W  = 32,
   localparam int SRC_W  = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic [NUM_REQ-1:0]        fu_valid,
   output logic [NUM_REQ-1:0]        fu_ready,
   input  logic [NUM_REQ*TAG_W-1:0]  fu_tag,
   input  logic [NUM_REQ*PHY_W-1:0]  fu_phy_reg,
   input  logic [NUM_REQ*DATA_W-1:0] fu_data,
   output logic                      cdb_valid,
   output logic [TAG_W-1:0]          cdb_tag,
   output logic [PHY_W-1:0]          cdb_phy_reg,
   output logic [DATA_W-1:0]         cdb_data,
   output logic [SRC_W-1:0]          cdb_src
);

   logic [NUM_REQ-1:0] buf_valid;
   logic [TAG_W-1:0]   buf_tag  [NUM_REQ];
   logic [PHY_W-1:0]   buf_phy  [NUM_REQ];
   logic [DATA_W-1:0]  buf_data [NUM_REQ];
   logic [SRC_W-1:0]   rr_ptr;

   logic               hi_found;
   logic               lo_found;
   logic [SRC_W-1:0]   hi_idx;
   logic [SRC_W-1:0]   lo_idx;
   logic               grant_any;
   logic [SRC_W-1:0]   grant_idx;
   logic [SRC_W-1:0]   rr_next;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] capture;
   logic [TAG_W-1:0]   sel_tag;
   logic [PHY_W-1:0]   sel_phy;
   logic [DATA_W-1:0]  sel_data;

   // Two-segment priority search: lowest valid index at/above rr_ptr wins,
   // otherwise lowest valid index below rr_ptr (the wrapped part of the ring).
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (buf_valid[i]) begin
            if (i >= int'(rr_ptr)) begin
               hi_found = 1'b1;
               hi_idx   = SRC_W'(i);
            end else begin
               lo_found = 1'b1;
               lo_idx   = SRC_W'(i);
            end
         end
      end
      grant_any = hi_found | lo_found;
      grant_idx = hi_found ? hi_idx : lo_idx;
   end

   always_comb begin
      grant    = '0;
      sel_tag  = '0;
      sel_phy  = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_any && (grant_idx == SRC_W'(i))) begin
            grant[i] = 1'b1;
            sel_tag  = buf_tag[i];
            sel_phy  = buf_phy[i];
            sel_data = buf_data[i];
         end
      end
   end

   assign rr_next = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

   // A buffer being drained this cycle can be refilled in the same cycle.
   assign fu_ready = (reset && !flush) ? (~buf_valid | grant) : '0;
   assign capture  = fu_valid & fu_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            buf_tag[i]  <= '0;
            buf_phy[i]  <= '0;
            buf_data[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (capture[i]) begin
               buf_tag[i]  <= fu_tag[i*TAG_W +: TAG_W];
               buf_phy[i]  <= fu_phy_reg[i*PHY_W +: PHY_W];
               buf_data[i] <= fu_data[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf_valid   <= '0;
         rr_ptr      <= '0;
         cdb_valid   <= 1'b0;
         cdb_tag     <= '0;
         cdb_phy_reg <= '0;
         cdb_data    <= '0;
         cdb_src     <= '0;
      end else if (flush) begin
         buf_valid <= '0;
         cdb_valid <= 1'b0;
      end else begin
         buf_valid <= (buf_valid & ~grant) | capture;
         cdb_valid <= grant_any;
         if (grant_any) begin
            cdb_tag     <= sel_tag;
            cdb_phy_reg <= sel_phy;
            cdb_data    <= sel_data;
            cdb_src     <= grant_idx;
            rr_ptr      <= rr_next;
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a queue-based reference model predicts fu_ready and
// every broadcast (payload, source, cycle); a negedge monitor pops and compares.
module tb_cdb_arbiter;
   localparam int NREQ   = 3;
   localparam int TAG_W  = 5;
   localparam int PHY_W  = 6;
   localparam int DATA_W = 32;
   localparam int SRC_W  = 2;

   logic                   clk;
   logic                   reset;
   logic                   flush;
   logic [NREQ-1:0]        fu_valid;
   logic [NREQ-1:0]        fu_ready;
   logic [NREQ*TAG_W-1:0]  fu_tag;
   logic [NREQ*PHY_W-1:0]  fu_phy_reg;
   logic [NREQ*DATA_W-1:0] fu_data;
   logic                   cdb_valid;
   logic [TAG_W-1:0]       cdb_tag;
   logic [PHY_W-1:0]       cdb_phy_reg;
   logic [DATA_W-1:0]      cdb_data;
   logic [SRC_W-1:0]       cdb_src;

   cdb_arbiter dut (
      .clk(clk), .reset(reset), .flush(flush),
      .fu_valid(fu_valid), .fu_ready(fu_ready),
      .fu_tag(fu_tag), .fu_phy_reg(fu_phy_reg), .fu_data(fu_data),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_phy_reg(cdb_phy_reg),
      .cdb_data(cdb_data), .cdb_src(cdb_src)
   );

   typedef struct {
      logic [TAG_W-1:0]  tag;
      logic [PHY_W-1:0]  phy;
      logic [DATA_W-1:0] data;
      logic [SRC_W-1:0]  src;
      int                due;
   } exp_t;

   exp_t sb[$];
   exp_t last_bc;
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   // reference model: which requesters hold an accepted, not-yet-broadcast result
   bit                m_pend [NREQ];
   logic [TAG_W-1:0]  m_tag  [NREQ];
   logic [PHY_W-1:0]  m_phy  [NREQ];
   logic [DATA_W-1:0] m_data [NREQ];
   int                m_ptr;

   // requester side: an offer is held until accepted
   bit                off_v    [NREQ];
   logic [TAG_W-1:0]  off_tag  [NREQ];
   logic [PHY_W-1:0]  off_phy  [NREQ];
   logic [DATA_W-1:0] off_data [NREQ];
   logic [TAG_W-1:0]  seq_tag  [NREQ];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s cyc=%0d: actual=%0h required=%0h", name, cyc, act, req);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NREQ; i++) m_pend[i] = 1'b0;
      m_ptr = 0;
      sb.delete();
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < NREQ; i++) begin
         fu_valid[i]                      = off_v[i];
         fu_tag[i*TAG_W +: TAG_W]         = off_tag[i];
         fu_phy_reg[i*PHY_W +: PHY_W]     = off_phy[i];
         fu_data[i*DATA_W +: DATA_W]      = off_data[i];
      end
   endtask

   task automatic set_offer(input int i, input logic [TAG_W-1:0] t,
                            input logic [PHY_W-1:0] p, input logic [DATA_W-1:0] d);
      off_v[i]    = 1'b1;
      off_tag[i]  = t;
      off_phy[i]  = p;
      off_data[i] = d;
   endtask

   // One clock of stimulus; the model state after this task reflects the next edge.
   task automatic cycle_step(input int p0, input int p1, input int p2, input bit do_flush);
      int pct [NREQ];
      int g;
      int idx;
      logic [NREQ-1:0] exp_rdy;
      exp_t n;
      pct[0] = p0; pct[1] = p1; pct[2] = p2;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (!off_v[i] && (int'($urandom_range(99)) < pct[i])) begin
            set_offer(i, seq_tag[i], PHY_W'($urandom), $urandom);
            seq_tag[i] = seq_tag[i] + 1'b1;
         end
      end
      drive_inputs();
      flush = do_flush;
      #1;
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
         idx = (m_ptr + k) % NREQ;
         if (g < 0 && m_pend[idx]) g = idx;
      end
      for (int i = 0; i < NREQ; i++) exp_rdy[i] = !do_flush && (!m_pend[i] || g == i);
      chk("fu_ready", 64'(fu_ready), 64'(exp_rdy));
      if (do_flush) begin
         for (int i = 0; i < NREQ; i++) m_pend[i] = 1'b0;
      end else begin
         if (g >= 0) begin
            n.tag  = m_tag[g];
            n.phy  = m_phy[g];
            n.data = m_data[g];
            n.src  = SRC_W'(g);
            n.due  = cyc + 1;
            sb.push_back(n);
            m_pend[g] = 1'b0;
            m_ptr = (g + 1) % NREQ;
         end
         for (int i = 0; i < NREQ; i++) begin
            if (off_v[i] && exp_rdy[i]) begin
               m_pend[i] = 1'b1;
               m_tag[i]  = off_tag[i];
               m_phy[i]  = off_phy[i];
               m_data[i] = off_data[i];
               off_v[i]  = 1'b0;
            end
         end
      end
   endtask

   task automatic run(input int n, input int p0, input int p1, input int p2);
      for (int c = 0; c < n; c++) cycle_step(p0, p1, p2, 1'b0);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            if (cdb_valid) begin
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_bcast cyc=%0d: actual src=%0d tag=%0h required no broadcast",
                           cyc, cdb_src, cdb_tag);
               end else begin
                  mon_e = sb.pop_front();
                  chk("bcast_cycle", 64'(cyc), 64'(mon_e.due));
                  chk("bcast_src", 64'(cdb_src), 64'(mon_e.src));
                  chk("bcast_tag", 64'(cdb_tag), 64'(mon_e.tag));
                  chk("bcast_phy", 64'(cdb_phy_reg), 64'(mon_e.phy));
                  chk("bcast_data", 64'(cdb_data), 64'(mon_e.data));
                  last_bc = mon_e;
               end
            end else begin
               if (sb.size() > 0 && sb[0].due <= cyc) begin
                  mon_e = sb.pop_front();
                  total++;
                  bad++;
                  $display("FAIL missing_bcast cyc=%0d: actual cdb_valid=0 required src=%0d tag=%0h",
                           cyc, mon_e.src, mon_e.tag);
               end
               chk("hold_payload", 64'({cdb_tag, cdb_phy_reg, cdb_data}),
                   64'({last_bc.tag, last_bc.phy, last_bc.data}));
               chk("hold_src", 64'(cdb_src), 64'(last_bc.src));
            end
         end
      end
   end

   initial begin
      reset      = 1'b0;
      flush      = 1'b0;
      fu_valid   = '1;
      fu_tag     = '0;
      fu_phy_reg = '0;
      fu_data    = '0;
      for (int i = 0; i < NREQ; i++) begin
         off_v[i]   = 1'b0;
         seq_tag[i] = '0;
      end
      model_clear();
      last_bc = '{default: 0};

      #2;
      chk("reset_cdb_valid", 64'(cdb_valid), 64'(0));
      chk("reset_fu_ready", 64'(fu_ready), 64'(0));
      chk("reset_payload", 64'({cdb_tag, cdb_phy_reg, cdb_data, cdb_src}), 64'(0));
      fu_valid = '0;
      #20 reset = 1'b1;

      // single result: latency 2, then idle
      set_offer(0, 5'd3, 6'd10, 32'hDEADBEEF);
      cycle_step(0, 0, 0, 1'b0);
      run(4, 0, 0, 0);

      // all requesters streaming: round-robin 0,1,2,...
      run(30, 100, 100, 100);
      run(5, 0, 0, 0);

      // requester 2 intermittent while 0 and 1 stream
      run(40, 100, 100, 50);
      run(5, 0, 0, 0);

      // requester 1 alone, tags 0..15 back to back
      chk("stream_idle_offer", 64'(off_v[1]), 64'(0));
      seq_tag[1] = '0;
      run(16, 0, 100, 0);
      run(5, 0, 0, 0);

      // flush with all buffers full, then resume
      run(6, 100, 100, 100);
      chk("flush_all_pending", 64'({m_pend[2], m_pend[1], m_pend[0]}), 64'(3'b111));
      cycle_step(100, 100, 100, 1'b1);
      run(10, 100, 100, 100);
      run(5, 0, 0, 0);

      // randomized mix with occasional flushes
      for (int seg = 0; seg < 15; seg++) begin
         int a, b, c;
         a = int'($urandom_range(100));
         b = int'($urandom_range(100));
         c = int'($urandom_range(100));
         for (int k = 0; k < 20; k++) cycle_step(a, b, c, ($urandom_range(99) < 3));
      end
      run(6, 0, 0, 0);

      // reset while a broadcast is on the bus
      run(6, 100, 100, 100);
      @(posedge clk);
      #1;
      chk("pre_reset_valid", 64'(cdb_valid), 64'(sb.size() > 0 && sb[0].due == cyc));
      #1;
      reset    = 1'b0;
      fu_valid = '0;
      fu_valid[0] = 1'b1;
      #1;
      chk("midreset_cdb_valid", 64'(cdb_valid), 64'(0));
      chk("midreset_fu_ready", 64'(fu_ready), 64'(0));
      chk("midreset_payload", 64'({cdb_tag, cdb_phy_reg, cdb_data, cdb_src}), 64'(0));
      fu_valid = '0;
      model_clear();
      last_bc = '{default: 0};
      @(posedge clk);
      @(posedge clk);
      #3 reset = 1'b1;
      run(20, 100, 100, 100);
      run(8, 0, 0, 0);

      chk("scoreboard_empty", 64'(sb.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
